// File: rtl/ex_mem_reg_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
// This file holds the bus widths, the stall vector bit positions, the reset
// and boolean levels, and the per-edge action decode. The id_ex and mem_wb
// registers can reuse all of these.
package ex_mem_reg_pkg;

  localparam int REG_W       = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int STALL_BUS_W = 6;
  localparam int ACC_BUS_W   = 64;
  localparam int CNT_BUS_W   = 2;
  localparam int BUB_BUS_W   = 16;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic FALSE_V    = 1'b0;

  typedef logic [REG_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

  // Bit positions inside the global stall vector, from front to back.
  typedef enum logic [2:0] {
    STALL_PC    = 3'd0,
    STALL_IF_ID = 3'd1,
    STALL_ID_EX = 3'd2,
    STALL_EX    = 3'd3,
    STALL_MEM   = 3'd4,
    STALL_WB    = 3'd5
  } stall_idx_e;

  // What a pipeline register does on a given clock edge.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_HOLD    = 2'd3
  } stage_action_e;

  // Flush beats everything. An unstalled producer always advances; this also
  // covers the illegal pattern where the consumer is stalled and the producer
  // is not. A stalled producer feeding a running consumer leaves a bubble.
  function automatic stage_action_e decode_action(input logic flush,
                                                  input logic own_stall,
                                                  input logic next_stall);
    stage_action_e act;
    if (flush)
      act = ACT_FLUSH;
    else if (!own_stall)
      act = ACT_ADVANCE;
    else if (!next_stall)
      act = ACT_BUBBLE;
    else
      act = ACT_HOLD;
    return act;
  endfunction

  function automatic logic inserts_bubble(input stage_action_e act);
    return (act == ACT_FLUSH) || (act == ACT_BUBBLE);
  endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// Bundle of the EX-side inputs, the MEM-side outputs and the accumulate
// feedback that runs between EX, the EX/MEM register and MEM.
// The master modport is the side that drives EX results and observes the
// register. The slave modport is the register itself.
interface ex_mem_reg_if
  import ex_mem_reg_pkg::*;
#(
  parameter int ACC_W = ACC_BUS_W,
  parameter int CNT_W = CNT_BUS_W
);

  reg_bus_t         ex_ans;
  logic             ex_write_enable;
  reg_addr_bus_t    ex_write_addr;
  logic [ACC_W-1:0] ex_acc_temp;
  logic [CNT_W-1:0] ex_cnt;

  reg_bus_t         mem_ans;
  logic             mem_write_enable;
  reg_addr_bus_t    mem_write_addr;
  logic             mem_valid;
  logic [ACC_W-1:0] acc_temp_o;
  logic [CNT_W-1:0] cnt_o;

  modport master (
    output ex_ans, ex_write_enable, ex_write_addr, ex_acc_temp, ex_cnt,
    input  mem_ans, mem_write_enable, mem_write_addr, mem_valid,
    input  acc_temp_o, cnt_o
  );

  modport slave (
    input  ex_ans, ex_write_enable, ex_write_addr, ex_acc_temp, ex_cnt,
    output mem_ans, mem_write_enable, mem_write_addr, mem_valid,
    output acc_temp_o, cnt_o
  );

endinterface

// File: rtl/ex_mem_reg_bubble_counter.sv
// Saturating event counter with an enable and an asynchronous reset.
// The count sticks at all-ones instead of wrapping, so a long-running debug
// read never reports a small value after an overflow.
module ex_mem_reg_bubble_counter
  import ex_mem_reg_pkg::*;
#(
  parameter int W = BUB_BUS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_p1;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    logic [W-1:0] one;
    one = {{(W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // Count one event per enabled edge, stopping at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE)
      count_p1 <= '0;
    else if (en)
      count_p1 <= sat_inc(count_p1);
  end

  assign count = count_p1;

endmodule

// File: rtl/ex_mem_reg.sv
// EX -> MEM pipeline register.
// It handles flush, bubble insertion and hold for the EX/MEM stage boundary.
// While EX is stalled, it also returns the multi-cycle accumulate state
// (partial result plus step count) to EX. Occupancy is visible through
// mem_valid and a saturating bubble counter.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int STALL_W = STALL_BUS_W,
  parameter int EX_IDX  = int'(STALL_EX),
  parameter int ACC_W   = ACC_BUS_W,
  parameter int CNT_W   = CNT_BUS_W,
  parameter int BUB_W   = BUB_BUS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_reg_if.slave        bus,
  output logic [BUB_W-1:0]   bubble_cnt
);

  if (EX_IDX + 1 >= STALL_W) begin : g_bad_idx
    $error("EX_IDX+1 must index inside the stall vector");
  end

  logic          own_stall;
  logic          next_stall;
  stage_action_e action;
  logic          bubble_en;

  // Only the EX bit and the MEM bit matter here. The rest of the vector is
  // consumed so that no bit is left dangling.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign own_stall  = stall[EX_IDX];
  assign next_stall = stall[EX_IDX+1];
  assign action     = decode_action(flush, own_stall, next_stall);
  assign bubble_en  = inserts_bubble(action);

  reg_bus_t         ans_p1;
  logic             we_p1;
  reg_addr_bus_t    addr_p1;
  logic             vld_p1;
  logic [ACC_W-1:0] acc_p1;
  logic [CNT_W-1:0] cnt_p1;

  // ---- EX -> MEM stage boundary ----
  // Update the MEM-facing payload and the accumulate feedback according to
  // the edge action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      ans_p1  <= '0;
      we_p1   <= FALSE_V;
      addr_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p1  <= '0;
      cnt_p1  <= '0;
    end else begin
      case (action)
        ACT_FLUSH: begin
          ans_p1  <= '0;
          we_p1   <= FALSE_V;
          addr_p1 <= '0;
          vld_p1  <= 1'b0;
          acc_p1  <= '0;
          cnt_p1  <= '0;
        end
        ACT_BUBBLE: begin
          ans_p1  <= '0;
          we_p1   <= FALSE_V;
          addr_p1 <= '0;
          vld_p1  <= 1'b0;
          acc_p1  <= bus.ex_acc_temp;
          cnt_p1  <= bus.ex_cnt;
        end
        ACT_ADVANCE: begin
          ans_p1  <= bus.ex_ans;
          we_p1   <= bus.ex_write_enable;
          addr_p1 <= bus.ex_write_addr;
          vld_p1  <= 1'b1;
          acc_p1  <= '0;
          cnt_p1  <= '0;
        end
        default: begin
          // Hold: both EX and MEM are frozen, so keep everything.
        end
      endcase
    end
  end

  assign bus.mem_ans          = ans_p1;
  assign bus.mem_write_enable = we_p1;
  assign bus.mem_write_addr   = addr_p1;
  assign bus.mem_valid        = vld_p1;
  assign bus.acc_temp_o       = acc_p1;
  assign bus.cnt_o            = cnt_p1;

  ex_mem_reg_bubble_counter #(
    .W (BUB_W)
  ) u_bubble_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (bubble_en),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for the EX/MEM pipeline register. A driver applies one stimulus per
// cycle and queues the state the register should hold after that edge. A
// monitor checks every registered output against the queue after each edge.
module tb_ex_mem_reg;

  localparam int EX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [15:0] bubble_cnt;

  ex_mem_reg_if #(.ACC_W(64), .CNT_W(2)) bus ();

  ex_mem_reg dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ans;
    logic        we;
    logic [4:0]  addr;
    logic        vld;
    logic [63:0] acc;
    logic [1:0]  cnt;
    logic [15:0] bub;
  } exp_t;

  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // Reference state: what MEM and the EX feedback should hold after each
  // edge. Bubbles are counted without bound, and the counter limit is
  // applied when the expected value is formed.
  logic [31:0] m_ans;
  logic        m_we;
  logic [4:0]  m_addr;
  logic        m_vld;
  logic [63:0] m_acc;
  logic [1:0]  m_cnt;
  int          bubbles_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ans = '0; m_we = 1'b0; m_addr = '0; m_vld = 1'b0;
    m_acc = '0; m_cnt = '0; bubbles_total = 0;
  endtask

  task automatic clear_mem();
    m_ans = '0; m_we = 1'b0; m_addr = '0; m_vld = 1'b0;
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge state.
  task automatic step(input logic fl, input logic [5:0] st, input logic [31:0] a,
                      input logic we, input logic [4:0] ad,
                      input logic [63:0] acc, input logic [1:0] c);
    exp_t e;
    flush = fl;
    stall = st;
    bus.ex_ans = a;
    bus.ex_write_enable = we;
    bus.ex_write_addr = ad;
    bus.ex_acc_temp = acc;
    bus.ex_cnt = c;
    if (fl) begin
      clear_mem();
      m_acc = '0; m_cnt = '0;
      bubbles_total++;
    end else if (!st[EX]) begin
      m_ans = a; m_we = we; m_addr = ad; m_vld = 1'b1;
      m_acc = '0; m_cnt = '0;
    end else if (!st[EX+1]) begin
      clear_mem();
      m_acc = acc; m_cnt = c;
      bubbles_total++;
    end
    e.ans = m_ans; e.we = m_we; e.addr = m_addr; e.vld = m_vld;
    e.acc = m_acc; e.cnt = m_cnt;
    e.bub = (bubbles_total > 65535) ? 16'hFFFF : 16'(bubbles_total);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_ans"}, 64'(bus.mem_ans), 64'd0);
    check({tag, ".mem_we"}, 64'(bus.mem_write_enable), 64'd0);
    check({tag, ".mem_addr"}, 64'(bus.mem_write_addr), 64'd0);
    check({tag, ".mem_valid"}, 64'(bus.mem_valid), 64'd0);
    check({tag, ".acc_temp_o"}, bus.acc_temp_o, 64'd0);
    check({tag, ".cnt_o"}, 64'(bus.cnt_o), 64'd0);
    check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'd0);
  endtask

  // The stall controller only issues monotonic stall vectors.
  always @(posedge clk) begin
    if (!rst)
      assert (!(stall[EX+1] && !stall[EX])) else $error("non-monotonic stall vector driven");
  end

  // Monitor: compare each edge's registered outputs with the queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("mem_ans", 64'(bus.mem_ans), 64'(e.ans));
        check("mem_write_enable", 64'(bus.mem_write_enable), 64'(e.we));
        check("mem_write_addr", 64'(bus.mem_write_addr), 64'(e.addr));
        check("mem_valid", 64'(bus.mem_valid), 64'(e.vld));
        check("acc_temp_o", bus.acc_temp_o, e.acc);
        check("cnt_o", 64'(bus.cnt_o), 64'(e.cnt));
        check("bubble_cnt", 64'(bubble_cnt), 64'(e.bub));
      end
    end
  end

  initial begin : driver
    logic [5:0] st;
    int k;
    bus.ex_ans = '0; bus.ex_write_enable = 1'b0; bus.ex_write_addr = '0;
    bus.ex_acc_temp = '0; bus.ex_cnt = '0;
    model_reset();

    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Advance.
    step(1'b0, 6'b000000, 32'hDEADBEEF, 1'b1, 5'd7, 64'h0, 2'd0);
    // Bubble with accumulate capture, then release.
    step(1'b0, 6'b001111, 32'h11111111, 1'b1, 5'd3, 64'h0000_0001_FFFF_0000, 2'd1);
    step(1'b0, 6'b000000, 32'h22222222, 1'b0, 5'd9, 64'h0000_0000_0000_1234, 2'd2);
    // Hold while the EX result keeps changing.
    step(1'b0, 6'b000000, 32'hCAFEF00D, 1'b1, 5'd12, 64'h0, 2'd0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 6'b011111, $urandom, 1'b1, 5'($urandom), {$urandom, $urandom}, 2'($urandom));
    // Flush overrides the hold pattern.
    step(1'b1, 6'b011111, 32'h33333333, 1'b1, 5'd4, 64'h55, 2'd3);
    // A write to r0 passes through unchanged.
    step(1'b0, 6'b000011, 32'h44444444, 1'b1, 5'd0, 64'h0, 2'd0);

    // Randomised monotonic stall vectors, with an occasional flush.
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 6);
      st = 6'((1 << k) - 1);
      step(($urandom_range(0, 7) == 0), st, $urandom, 1'($urandom), 5'($urandom),
           {$urandom, $urandom}, 2'($urandom));
    end

    // Asynchronous reset asserted mid-cycle with live data in MEM.
    step(1'b0, 6'b000000, 32'h12345678, 1'b1, 5'd21, 64'h0, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    // The first edge after reset already has EX stalled.
    step(1'b0, 6'b001111, 32'h0, 1'b0, 5'd0, 64'h0000_0001_FFFF_0000, 2'd1);

    // Drive the bubble counter past saturation, then confirm it stays put.
    for (int i = 0; i < 65540; i++)
      step(i[0], 6'b001111, $urandom, 1'b1, 5'($urandom), {$urandom, $urandom}, 2'($urandom));
    step(1'b0, 6'b000000, 32'hABCD0123, 1'b1, 5'd30, 64'h0, 2'd0);
    step(1'b1, 6'b000000, 32'h0, 1'b0, 5'd0, 64'h0, 2'd0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage; it drives MEM's ans_i, write_enable_i and write_addr_i inputs.
- Supports per-stage stall, bubble insertion and flush.
- Carries the multi-cycle accumulate state (partial 64-bit result plus step counter) back to EX while EX is stalled.
- Occupancy is tracked through a valid bit and a bubble counter for debug and performance visibility.

Parameters:
- STALL_W, 6, width of the global stall vector: bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex, bit4 mem, bit5 wb.
- EX_IDX, 3, stall bit owned by the EX stage.
- ACC_W, 64, width of the multi-cycle accumulate temporary.
- CNT_W, 2, width of the multi-cycle step counter.
- BUB_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset (`rst_enable = 1)
- stall  in  STALL_W  stall request vector from the stall controller
- flush  in  1  exception/redirect flush; squashes the EX result
- ex_ans  in  `reg_bus (32)  EX result
- ex_write_enable  in  1  EX register-file write request
- ex_write_addr  in  `reg_addr_bus (5)  EX destination register
- ex_acc_temp  in  ACC_W  partial accumulate result from EX
- ex_cnt  in  CNT_W  current accumulate step from EX
- mem_ans  out  32  to MEM ans_i
- mem_write_enable  out  1  to MEM write_enable_i
- mem_write_addr  out  5  to MEM write_addr_i
- mem_valid  out  1  1 = MEM holds a real instruction; 0 = bubble
- acc_temp_o  out  ACC_W  held partial result back to EX
- cnt_o  out  CNT_W  held step count back to EX
- bubble_cnt  out  BUB_W  saturating count of bubbles inserted

Behaviour:
- Reset (asynchronous, while rst=1): all outputs 0; mem_write_enable = `false_v; mem_valid = 0; bubble_cnt = 0.
- All updates happen on the rising edge of clk. Latency is 1 cycle from ex_* to mem_*.
- Priority per edge, highest first:
  1. flush=1: insert a bubble. mem_ans=0, mem_write_enable=0, mem_write_addr=0, mem_valid=0. acc_temp_o=0, cnt_o=0. bubble_cnt increments. Flush overrides any stall pattern.
  2. stall[EX_IDX]=1 and stall[EX_IDX+1]=0: EX is stalled but MEM proceeds, so insert a bubble. mem_* are cleared as in 1 and mem_valid=0. acc_temp_o<=ex_acc_temp and cnt_o<=ex_cnt, so EX sees its partial state next cycle. bubble_cnt increments.
  3. stall[EX_IDX]=0: normal advance. mem_ans<=ex_ans, mem_write_enable<=ex_write_enable, mem_write_addr<=ex_write_addr, mem_valid<=1. acc_temp_o=0 and cnt_o=0, since the multi-cycle operation has completed.
  4. stall[EX_IDX]=1 and stall[EX_IDX+1]=1: hold. Every output, including acc_temp_o, cnt_o and bubble_cnt, keeps its value.
- bubble_cnt saturates at all-ones and never wraps.
- Stall bits other than EX_IDX and EX_IDX+1 are ignored by this block.
- ex_write_addr=0 with ex_write_enable=1 passes through unchanged. Suppressing writes to r0 belongs to the register file.
- When rst deasserts with a stall already active, the first edge follows the normal priority rules against the reset state.
- An illegal stall pattern (stall[EX_IDX+1]=1 with stall[EX_IDX]=0) is treated as case 3. MEM is then overwritten: the stall controller guarantees monotonic stall vectors, and the bench asserts this pattern never occurs.
- No combinational path from inputs to outputs.

Decomposition:
- Shared defines header gains: stall_bus (STALL_W-1:0), stall bit indices (stall_pc=0 … stall_wb=5), acc_bus (63:0), cnt_bus (1:0).
- Existing `reg_bus, `reg_addr_bus, `rst_enable, `false_v are reused.
- One sub-module is natural: bubble_counter, a saturating counter with enable and asynchronous reset. It is reusable by id_ex and mem_wb.
- The remaining state is a single always block with an asynchronous reset branch.

Test Plan:
- Reset: assert rst mid-cycle while mem_ans=0x12345678 → all outputs 0 immediately, before the next clk edge; bubble_cnt=0.
- Advance: stall=6'b000000, ex_ans=0xDEADBEEF, we=1, addr=5'd7 → after 1 edge: mem_ans=0xDEADBEEF, mem_write_enable=1, mem_write_addr=7, mem_valid=1, cnt_o=0.
- Bubble with state capture: stall=6'b001111, ex_acc_temp=0x0000_0001_FFFF_0000, ex_cnt=1 → mem_write_enable=0, mem_valid=0, acc_temp_o=0x0000_0001_FFFF_0000, cnt_o=1, bubble_cnt +1. Then stall=0 → cnt_o=0, acc_temp_o=0.
- Hold: load 0xCAFEF00D, then stall=6'b011111 for 3 edges while ex_ans changes → mem_ans stays 0xCAFEF00D and bubble_cnt unchanged.
- Flush vs stall: stall=6'b011111 together with flush=1 → mem_valid=0, mem_ans=0, cnt_o=0 (flush wins).
- Saturation: force 65540 bubbles → bubble_cnt=0xFFFF and remains there.
